// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl -- multiply/divide unit controller with architectural HI/LO.
//
// A mult/multu/div/divu presented in E with start=1 is evaluated on the start
// edge and the 64-bit result is parked in hi_res/lo_res. The unit then sits in
// BUSY for a fixed latency (5 cycles for multiplies, 10 for divides) to model
// an iterative datapath, after which the parked result is committed to HI/LO.
// mthi/mtlo writes are accepted only while idle.
//
// Ports
//   clk       in   1  system clock, rising edge
//   reset     in   1  synchronous active-high reset
//   start     in   1  E-stage instruction is mult/multu/div/divu
//   md_op     in   2  00=mult 01=multu 10=div 11=divu
//   A, B      in  32  E-stage rs / rt operand values
//   hi_we     in   1  mthi write enable (E stage)
//   lo_we     in   1  mtlo write enable (E stage)
//   wd        in  32  mthi/mtlo write data
//   md_use_D  in   1  D-stage instruction uses the MDU or HI/LO
//   busy      out  1  operation in flight
//   stall_md  out  1  combinational stall request to the stall unit
//   HI, LO    out 32  architectural HI / LO registers
// -----------------------------------------------------------------------------
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wd,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Down-counter reload values: the edge with cnt==0 is the completion edge,
  // so busy lasts (reload + 1) cycles.
  localparam logic [3:0] MUL_CYCLES = 4'd4;
  localparam logic [3:0] DIV_CYCLES = 4'd9;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] hi_res;
  logic [31:0] lo_res;
  logic        res_commit;   // cleared for divide-by-zero: HI/LO stay put

  // ---------------------------------------------------------------------------
  // Result datapath (evaluated only on the start edge)
  // ---------------------------------------------------------------------------
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] a_mag, b_mag, divisor;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        q_neg;
  logic        div_by_zero;
  logic [31:0] hi_nxt, lo_nxt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case statements can leave a value held, which would infer a latch.
    hi_nxt = '0;
    lo_nxt = '0;

    // Signed product from sign-extended operands: the low 64 bits of an
    // unsigned 64x64 multiply of two's-complement values are the signed product.
    a_sx   = {{32{A[31]}}, A};
    b_sx   = {{32{B[31]}}, B};
    prod_s = a_sx * b_sx;
    prod_u = {32'b0, A} * {32'b0, B};

    // Signed division on magnitudes. Quotient sign is the XOR of operand
    // signs, remainder follows the dividend. 0x80000000 / -1 falls out
    // naturally: magnitude 2^31 negated twice wraps back to 0x80000000, rem 0.
    div_by_zero = (B == 32'd0);
    divisor     = div_by_zero ? 32'd1 : B;   // keep the divider defined
    a_mag       = A[31] ? (~A + 32'd1) : A;
    b_mag       = divisor[31] ? (~divisor + 32'd1) : divisor;
    q_mag       = a_mag / b_mag;
    r_mag       = a_mag % b_mag;
    q_neg       = A[31] ^ divisor[31];
    q_s         = q_neg ? (~q_mag + 32'd1) : q_mag;
    r_s         = A[31] ? (~r_mag + 32'd1) : r_mag;
    q_u         = A / divisor;
    r_u         = A % divisor;

    unique case (md_op)
      OP_MULT:  begin hi_nxt = prod_s[63:32]; lo_nxt = prod_s[31:0]; end
      OP_MULTU: begin hi_nxt = prod_u[63:32]; lo_nxt = prod_u[31:0]; end
      OP_DIV:   begin hi_nxt = r_s;           lo_nxt = q_s;          end
      OP_DIVU:  begin hi_nxt = r_u;           lo_nxt = q_u;          end
      default:  begin hi_nxt = '0;            lo_nxt = '0;           end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM, counter and architectural registers
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_res     <= '0;
      lo_res     <= '0;
      res_commit <= 1'b0;
      HI         <= '0;
      LO         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            // start wins over a coincident mthi/mtlo
            hi_res     <= hi_nxt;
            lo_res     <= lo_nxt;
            res_commit <= !(md_op[1] && div_by_zero);
            cnt        <= md_op[1] ? DIV_CYCLES : MUL_CYCLES;
            state      <= BUSY;
          end else begin
            if (hi_we) HI <= wd;
            if (lo_we) LO <= wd;
          end
        end
        BUSY: begin
          // start/hi_we/lo_we are deliberately not looked at in this state
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (res_commit) begin
              HI <= hi_res;
              LO <= lo_res;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == BUSY);
  assign stall_md = md_use_D & (start | busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl -- self-checking bench for mdu_ctrl.
// Directed table of operations, hand-written reset sequences, then randomized
// operations and mthi/mtlo writes checked against an arithmetic model of HI/LO.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] A, B;
  logic        hi_we, lo_we;
  logic [31:0] wd;
  logic        md_use_D;
  logic        busy, stall_md;
  logic [31:0] HI, LO;

  mdu_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .A        (A),
    .B        (B),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wd       (wd),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall_md (stall_md),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference HI/LO
  logic [31:0] m_hi, m_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Architectural effect of one MDU operation, from plain integer arithmetic.
  function automatic void model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      2'd2: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      default: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
    endcase
  endfunction

  // mthi/mtlo in idle, then compare HI/LO with the model.
  task automatic mt_write(input logic h, input logic l, input logic [31:0] w);
    @(posedge clk); #1;
    hi_we = h; lo_we = l; wd = w;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (h) m_hi = w;
    if (l) m_lo = w;
    @(negedge clk);
    check("mt_hi", HI, m_hi);
    check("mt_lo", LO, m_lo);
  endtask

  // Issue one operation, count busy cycles, check stall on every cycle and
  // HI/LO in the first idle cycle. clash drives mthi/mtlo on the start cycle;
  // noise drives start/mthi/mtlo and scrambles operands while busy.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic use_d, input logic clash, input logic noise,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    int exp_cycles;
    exp_cycles = op[1] ? 10 : 5;
    n = 0;
    @(posedge clk); #1;
    start = 1'b1; md_op = op; A = a; B = b; md_use_D = use_d;
    hi_we = clash; lo_we = clash; wd = $urandom;
    @(negedge clk);
    check("start_stall", stall_md, use_d);
    check("start_busy", busy, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    md_op = 2'($urandom); A = $urandom; B = $urandom;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      check("busy_stall", stall_md, use_d);
      if (noise && n < exp_cycles) begin
        start = 1'($urandom); hi_we = 1'($urandom); lo_we = 1'($urandom);
        wd = $urandom; md_op = 2'($urandom); A = $urandom; B = $urandom;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
    end
    check("busy_cycles", 64'(n), 64'(exp_cycles));
    check("idle_stall", stall_md, 1'b0);
    check("res_hi", HI, exp_hi);
    check("res_lo", LO, exp_lo);
    m_hi = HI === exp_hi ? exp_hi : exp_hi;
    m_lo = exp_lo;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        use_d;
    logic        preload;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'd0, 32'hFFFF_FFFE, 32'd3,        1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{2'd1, 32'hFFFF_FFFE, 32'd3,        1'b0, 1'b0, 32'h0000_0002, 32'hFFFF_FFFA};
    vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,        1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'd3, 32'd5,         32'd0,        1'b0, 1'b1, 32'h0000_0011, 32'h0000_0022};
    vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'd3, 32'd100,       32'd7,        1'b0, 1'b0, 32'd2,         32'd14};
    vecs[6] = '{2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[7] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0, 32'd1,         32'hFFFF_FFFD};

    // Reset with start/mthi/mtlo also asserted: reset must win.
    reset = 1'b1; start = 1'b1; md_op = 2'd0; A = 32'd3; B = 32'd4;
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'hDEAD_BEEF; md_use_D = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_stall_comb", stall_md, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; md_use_D = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_hi", HI, 32'd0);
    check("post_rst_stall", stall_md, 1'b0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].preload) begin
        mt_write(1'b1, 1'b0, 32'h11);
        mt_write(1'b0, 1'b1, 32'h22);
      end
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_d, 1'b0, 1'b0,
            vecs[i].hi, vecs[i].lo);
    end

    // Reset mid-divide: reset during busy cycle 4 aborts, nothing commits.
    mt_write(1'b1, 1'b1, 32'h5555_AAAA);
    @(posedge clk); #1;
    start = 1'b1; md_op = 2'd2; A = 32'hFFFF_FFF9; B = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_c4", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    repeat (8) @(negedge clk);
    check("abort_no_commit_lo", LO, 32'd0);
    m_hi = '0; m_lo = '0;
    do_op(2'd0, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0, 32'd42);

    // Start coinciding with mthi/mtlo: the write is dropped.
    m_hi = HI; m_lo = LO;
    model_op(2'd1, 32'd9, 32'd9);
    do_op(2'd1, 32'd9, 32'd9, 1'b1, 1'b1, 1'b0, m_hi, m_lo);

    // Randomized operations and writes against the model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      if ($urandom_range(3) == 0) begin
        mt_write(1'($urandom), 1'($urandom), $urandom);
      end else begin
        op = 2'($urandom);
        a  = $urandom;
        case ($urandom_range(3))
          0: b = 32'd0;
          1: b = 32'($urandom_range(15));
          2: b = 32'hFFFF_FFFF;
          default: b = $urandom;
        endcase
        if ($urandom_range(7) == 0) a = 32'h8000_0000;
        model_op(op, a, b);
        do_op(op, a, b, 1'($urandom), 1'($urandom), 1'($urandom), m_hi, m_lo);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have clock and reset as follows: one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: the E-stage instruction is mult/multu/div/divu.
REQ-005 The block SHALL have port md_op, input, 2 bits: operation code, where 00=mult, 01=multu, 10=div, 11=divu.
REQ-006 The block SHALL have ports A and B, input, 32 bits each: E-stage rs and rt operand values.
REQ-007 The block SHALL have ports hi_we and lo_we, input, 1 bit each: write enables for mthi and mtlo in E.
REQ-008 The block SHALL have port wd, input, 32 bits: write data for mthi and mtlo.
REQ-009 The block SHALL have port md_use_D, input, 1 bit: the D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-011 The block SHALL have port stall_md, output, 1 bit: combinational stall request to the pipeline stall unit.
REQ-012 The block SHALL have ports HI and LO, output, 32 bits each: architectural HI and LO registers.

Function
REQ-013 The block SHALL have two states, IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-014 In IDLE with start=1 at a clock edge, the block SHALL:
- latch the result of md_op on A and B into internal registers hi_res and lo_res;
- load cnt with 4 for mult/multu or 9 for div/divu;
- enter BUSY.
REQ-015 In BUSY, each clock edge with cnt!=0 SHALL decrement cnt.
REQ-016 The edge in BUSY with cnt==0 SHALL copy hi_res/lo_res into HI/LO and return to IDLE.
REQ-017 Result latency SHALL be as follows:
- busy is high for exactly 5 cycles (mult/multu) or 10 cycles (div/divu), beginning the cycle after the start edge;
- new HI/LO are visible in the first cycle busy is low.
REQ-018 The operations SHALL compute:
- mult: signed 32x32 to 64-bit product, with {HI,LO}=product;
- multu: the same, unsigned;
- div: LO=signed quotient and HI=signed remainder, truncating toward zero, with the remainder taking the sign of the dividend;
- divu: the same, unsigned.
REQ-019 For div/divu with B==0, the block SHALL still run the full 10-cycle busy period, and HI/LO SHALL be left unchanged at completion.
REQ-020 For div with A=0x80000000 and B=0xFFFFFFFF, the block SHALL produce LO=0x80000000 and HI=0.
REQ-021 busy SHALL equal (state==BUSY).
REQ-022 stall_md SHALL equal md_use_D & (start | busy).
REQ-023 In IDLE, hi_we/lo_we SHALL write wd into HI/LO at the clock edge.
- If hi_we and lo_we are both set, both registers are written.
REQ-024 If start and hi_we/lo_we are both set in IDLE, start SHALL take precedence and the write SHALL be ignored.
REQ-025 start, hi_we and lo_we SHALL be ignored while in BUSY.
- No restart occurs and no HI/LO write occurs.
- REQ-022 guarantees this condition is not produced by a correct pipeline.
REQ-026 HI and LO SHALL change only on a completion edge (REQ-016) or on an IDLE mthi/mtlo write (REQ-023).
REQ-027 md_op SHALL be sampled only on the start edge.
- Changes to md_op or the operands during BUSY SHALL NOT affect the result.

Reset
REQ-028 reset=1 at a clock edge SHALL set:
- state=IDLE and cnt=0;
- HI=0 and LO=0;
- hi_res=0 and lo_res=0.
REQ-029 A reset asserted mid-operation SHALL abort the operation.
- busy=0 in the following cycle.
- No result is ever committed.
REQ-030 reset SHALL take precedence over start, hi_we and lo_we in the same cycle.
REQ-031 After reset, outputs SHALL be busy=0, HI=0 and LO=0.
- stall_md SHALL follow REQ-022 combinationally.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- mult timing: start, md_op=00, A=0xFFFFFFFE (-2), B=3 -> busy high cycles 1-5, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
- multu: the same operands with md_op=01 -> HI=0x00000002 and LO=0xFFFFFFFA.
- div timing and sign: md_op=10, A=-7, B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1).
- divide by zero: preload HI=0x11, LO=0x22 via mthi/mtlo, then divu with B=0 -> 10 busy cycles, HI=0x11 and LO=0x22.
- stall: md_use_D=1 on the start cycle and during busy -> stall_md=1 on each of those cycles and 0 on the first idle cycle; md_use_D=0 -> stall_md=0 throughout.
- reset mid-div: assert reset at busy cycle 4 -> busy=0, HI=0 and LO=0 the next cycle; a later mult of 6x7 completes with LO=42 and HI=0.
